// File: rtl/seq_sub.sv
// Bit/digit-serial unsigned subtractor: {bout, diff} = a - b - bin, DIGIT bits per cycle.
// Define SEQ_SUB_SAT_EN to clamp diff to zero whenever the final borrow is set.
module seq_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and ready may be high before valid.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic [DIGIT-1:0] slice;
    logic [CW-1:0]    cnt;
    logic             br, br_nx;
    logic             accept, last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(N - 1));

    // One DIGIT-wide ripple-borrow slice; the partial result fills from the top.
    always_comb begin
        br_nx = br;
        slice = '0;
        for (int i = 0; i < DIGIT; i++) begin
            slice[i] = a_sh[i] ^ b_sh[i] ^ br_nx;
            br_nx    = (~a_sh[i] & b_sh[i]) | (~a_sh[i] & br_nx) | (b_sh[i] & br_nx);
        end
        res_nx                     = res >> DIGIT;
        res_nx[WIDTH-1 -: DIGIT]   = slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // diff/bout only change on the edge entering DONE, so they hold through
    // back-pressure and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        res  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    res  <= res_nx;
                    br   <= br_nx;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        bout <= br_nx;
`ifdef SEQ_SUB_SAT_EN
                        diff <= br_nx ? '0 : res_nx;
`else
                        diff <= res_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
